// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the shared FIFO: burst-limited ownership,
// credit tracking from FIFO pops, and source-ID tagging of each written word.
module fifo_wr_arbiter #(
  parameter int  NREQ      = 4,
  parameter int  DW        = 8,
  parameter int  DEPTH     = 8,
  parameter int  BURST_MAX = 4,
  localparam int IDW       = $clog2(NREQ),
  localparam int OCW       = $clog2(DEPTH + 1),
  localparam int BCW       = $clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                fifo_wr_en,
  output logic [DW+IDW-1:0]   fifo_wr_data,
  input  logic                fifo_rd_en,
  output logic [OCW-1:0]      occupancy,
  output logic                credit_full,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_grant_id;
  logic [BCW-1:0]      r_burst_cnt;
  logic [OCW-1:0]      r_occ;
  logic                r_wr_en;
  logic [DW+IDW-1:0]   r_wr_data;

  logic                w_can_acc;
  logic                w_own_valid;
  logic                w_others_valid;
  logic                w_limit;
  logic                w_exit;
  logic                w_sel_found;
  logic                w_xfer;
  logic                w_pop;
  logic [IDW-1:0]      w_sel;
  logic [IDW-1:0]      w_idx;
  logic [IDW-1:0]      w_xfer_id;
  logic [NREQ-1:0]     w_owner_mask;
  logic [NREQ-1:0]     w_ready;
  logic [DW-1:0]       w_xfer_data;

  // Acceptance is gated by the registered occupancy, so a pop never frees a slot
  // for the same cycle.
  assign w_can_acc      = (r_occ < OCW'(DEPTH));
  assign w_own_valid    = req_valid[r_grant_id];
  assign w_owner_mask   = NREQ'(1) << r_grant_id;
  assign w_others_valid = |(req_valid & ~w_owner_mask);
  assign w_limit        = (r_burst_cnt == BCW'(BURST_MAX)) & w_others_valid;
  assign w_exit         = ~w_own_valid | w_limit;

  always_comb begin : rr_search
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_sel       = r_rr_ptr;
    w_sel_found = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_rr_ptr + IDW'(k);
      if (!w_sel_found && req_valid[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel       = w_idx;
      end
    end
  end

  always_comb begin : ready_gen
    w_ready = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:  if (w_sel_found) w_ready[w_sel] = w_can_acc;
        S_OWN:   w_ready[r_grant_id] = w_can_acc & w_own_valid & ~w_limit;
        default: w_ready = '0;
      endcase
    end
  end

  assign w_xfer      = |(req_valid & w_ready);
  assign w_xfer_id   = (r_state == S_OWN) ? r_grant_id : w_sel;
  assign w_xfer_data = req_data[w_xfer_id*DW +: DW];
  assign w_pop       = fifo_rd_en & (r_occ != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_occ       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) r_wr_data <= {w_xfer_id, w_xfer_data};

      if (w_xfer && !w_pop)      r_occ <= r_occ + OCW'(1);
      else if (!w_xfer && w_pop) r_occ <= r_occ - OCW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state     <= S_OWN;
            r_grant_id  <= w_sel;
            r_burst_cnt <= BCW'(1);
          end
        end
        S_OWN: begin
          // Leaving ownership hands priority to the next requester after the owner.
          if (w_exit) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= r_grant_id + IDW'(1);
          end else if (w_xfer && (r_burst_cnt != BCW'(BURST_MAX))) begin
            r_burst_cnt <= r_burst_cnt + BCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = w_ready;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_wr_data = r_wr_data;
  assign occupancy    = r_occ;
  assign credit_full  = (r_occ == OCW'(DEPTH));
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == S_OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4, DW = 8, DEPTH = 8, BURST_MAX = 4;
  localparam int IDW = 2, OCW = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                fifo_wr_en;
  logic [DW+IDW-1:0]   fifo_wr_data;
  logic                fifo_rd_en;
  logic [OCW-1:0]      occupancy;
  logic                credit_full;
  logic [IDW-1:0]      grant_id;
  logic                busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .occupancy(occupancy), .credit_full(credit_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic [DW+IDW-1:0] word;
  } exp_t;

  exp_t          sb[$];
  int            trace[$];
  int            n_vec = 0, n_miss = 0, cyc = 0;
  bit            mon_en = 1'b0;
  int            left[NREQ];
  logic [DW-1:0] cur[NREQ];

  // Reference model: words in the FIFO, arbitration owner, round-robin start, burst length.
  int m_occ = 0, m_rr = 0, m_owner = 0, m_burst = 0;
  bit m_own = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit   due;
    exp_t e;
    if (mon_en) begin
      due = (sb.size() > 0) && (sb[0].due <= cyc);
      check("fifo_wr_en", 32'(fifo_wr_en), 32'(due));
      if (due) begin
        e = sb.pop_front();
        check("fifo_wr_data", 32'(fifo_wr_data), 32'(e.word));
      end
    end
  end

  function automatic logic [NREQ-1:0] model_ready(input bit rst_v, input logic [NREQ-1:0] v,
                                                   output int sel, output bit lim);
    logic [NREQ-1:0] r;
    bit others;
    r = '0; sel = -1; lim = 1'b0; others = 1'b0;
    if (!rst_v) return r;
    if (!m_own) begin
      for (int k = 0; k < NREQ; k++)
        if (sel < 0 && v[(m_rr + k) % NREQ]) sel = (m_rr + k) % NREQ;
      if (sel >= 0) r[sel] = (m_occ < DEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) if (i != m_owner && v[i]) others = 1'b1;
      lim = (m_burst == BURST_MAX) && others;
      sel = m_owner;
      r[m_owner] = (m_occ < DEPTH) && v[m_owner] && !lim;
    end
    return r;
  endfunction

  // One clock: drive at negedge, check ready mid-phase, advance model, check registers at next negedge.
  task automatic step(input bit rd, input bit rst_v);
    logic [NREQ-1:0] er, da;
    int   sel, id;
    bit   lim, acc;
    exp_t e;
    rst_n      = rst_v;
    fifo_rd_en = rd;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = (left[i] > 0);
      req_data[i*DW +: DW]  = cur[i];
    end
    #1;
    er = model_ready(rst_v, req_valid, sel, lim);
    check("req_ready", 32'(req_ready), 32'(er));
    da = req_ready & req_valid;
    id = -1;
    for (int i = 0; i < NREQ; i++) if (da[i]) id = i;
    trace.push_back(id);
    acc = |(er & req_valid);
    if (!rst_v) begin
      m_occ = 0; m_rr = 0; m_owner = 0; m_burst = 0; m_own = 1'b0;
    end else begin
      if (acc) begin
        e.due  = cyc + 1;
        e.word = {IDW'(sel), cur[sel]};
        sb.push_back(e);
        left[sel]--;
        cur[sel] = DW'($urandom);
      end
      m_occ = m_occ + (acc ? 1 : 0) - ((rd && m_occ > 0) ? 1 : 0);
      if (!m_own) begin
        if (acc) begin m_own = 1'b1; m_owner = sel; m_burst = 1; end
      end else if (!req_valid[m_owner] || lim) begin
        m_own = 1'b0;
        m_rr  = (m_owner + 1) % NREQ;
      end else if (acc && m_burst < BURST_MAX) begin
        m_burst++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("occupancy",   32'(occupancy),   32'(m_occ));
    check("credit_full", 32'(credit_full), 32'(m_occ == DEPTH));
    check("busy",        32'(busy),        32'(m_own));
    check("grant_id",    32'(grant_id),    32'(m_owner));
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) left[i] = 0;
  endtask

  initial begin
    int exp2[11] = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, -1};
    int exp3[3]  = '{-1, 2, -1};
    int exp5[4]  = '{3, 3, -1, 0};
    int n2;

    rst_n = 1'b0; fifo_rd_en = 1'b0; req_valid = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; cur[i] = DW'($urandom); end
    @(negedge clk);
    mon_en = 1'b1;
    step(0, 0);

    // 1: single word from requester 0
    cur[0] = 8'hA5; left[0] = 1; trace.delete();
    step(0, 1);
    check("t1_grant", 32'(trace[0]), 32'(0));
    check("t1_wr_en", 32'(fifo_wr_en), 32'(1));
    check("t1_wr_data", 32'(fifo_wr_data), 32'h0A5);
    check("t1_occ", 32'(occupancy), 32'(1));
    step(0, 1);

    // 2: all requesters streaming, no pops, until credits run out
    clear_reqs(); step(0, 0);
    for (int i = 0; i < NREQ; i++) left[i] = 100;
    trace.delete();
    repeat (11) step(0, 1);
    for (int k = 0; k < 11; k++) check("t2_grant_seq", 32'(trace[k]), 32'(exp2[k]));
    check("t2_full", 32'(credit_full), 32'(1));
    check("t2_occ", 32'(occupancy), 32'(8));
    check("t2_ready", 32'(req_ready), 32'(0));

    // 3: one pop from full admits exactly one more word
    trace.delete();
    step(1, 1);
    check("t3_occ_after_pop", 32'(occupancy), 32'(7));
    step(0, 1);
    step(0, 1);
    for (int k = 0; k < 3; k++) check("t3_grant_seq", 32'(trace[k]), 32'(exp3[k]));
    check("t3_occ", 32'(occupancy), 32'(8));

    // 4: lone owner with pops every cycle: unbounded burst
    clear_reqs(); step(0, 0);
    left[2] = 10; trace.delete();
    repeat (10) step(1, 1);
    n2 = 0;
    foreach (trace[k]) if (trace[k] == 2) n2++;
    check("t4_burst_len", 32'(n2), 32'(10));
    check("t4_occ", 32'(occupancy), 32'(1));
    check("t4_busy", 32'(busy), 32'(1));
    step(1, 1);

    // 5: owner 3 drops valid while 0 waits
    clear_reqs(); step(0, 0);
    left[3] = 2; trace.delete();
    step(0, 1);
    left[0] = 3;
    repeat (3) step(0, 1);
    for (int k = 0; k < 4; k++) check("t5_grant_seq", 32'(trace[k]), 32'(exp5[k]));

    // 6: reset in the middle of a burst
    clear_reqs(); step(0, 0);
    for (int i = 0; i < NREQ; i++) left[i] = 100;
    for (int k = 0; k < 20 && occupancy != 4'd5; k++) step(0, 1);
    check("t6_occ_before", 32'(occupancy), 32'(5));
    step(0, 0);
    check("t6_occ", 32'(occupancy), 32'(0));
    check("t6_wr_en", 32'(fifo_wr_en), 32'(0));
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_ready", 32'(req_ready), 32'(0));
    clear_reqs();

    // Randomized traffic with random pops and rare resets
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++)
        if (left[i] == 0 && $urandom_range(3) == 0) left[i] = $urandom_range(6, 1);
      step($urandom_range(2) == 0, $urandom_range(299) != 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
